rr_sched16: RTL

- Round-robin scheduler that shares one 16:1 selection datapath among 16 requesters.
- It grants one requester at a time and drives the 4-bit select of the shared 16:1 mux.
- It enforces a bounded hold time per grant so that one requester cannot monopolise the datapath.
- It sits between the requesting agents and the mux select input; all outputs are registered.

---
 rtl/rr_sched16.sv | 108 ++++++++++
 1 files changed

// File: rtl/rr_sched16.sv
// rr_sched16: round-robin scheduler granting one of 16 requesters access to a
// shared 16:1 datapath, with a bounded hold time per grant. All outputs are
// registered; o_sel drives the shared mux select directly.
module rr_sched16 #(
   parameter int MAX_HOLD = 8   // 1..255
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_en,
   input  logic [15:0] i_req,
   input  logic        i_release,
   output logic [15:0] o_gnt,
   output logic [3:0]  o_sel,
   output logic        o_gnt_valid,
   output logic        o_timeout
);

   typedef enum logic {S_IDLE, S_GRANT} state_t;

   state_t      r_state;
   logic [3:0]  r_ptr;
   logic [7:0]  r_cnt;
   logic [15:0] r_gnt;
   logic [3:0]  r_sel;
   logic        r_gnt_valid;
   logic        r_timeout;

   logic        w_found;
   logic [3:0]  w_win;
   logic [3:0]  w_idx;
   logic        w_hold;
   logic        w_keep;
   logic        w_end;

   // Priority search starting at r_ptr and wrapping; first requester found wins.
   always_comb begin
      w_found = 1'b0;
      w_win   = 4'd0;
      w_idx   = 4'd0;
      for (int k = 0; k < 16; k++) begin
         w_idx = r_ptr + 4'(k);
         if (!w_found && i_req[w_idx]) begin
            w_found = 1'b1;
            w_win   = w_idx;
         end
      end
   end

   // Grant end conditions: the hold limit, a withdrawn request, or a release.
   always_comb begin
      w_hold = (r_cnt == 8'(MAX_HOLD - 1));
      w_keep = i_req[r_sel];
      w_end  = i_release | ~w_keep | w_hold;
   end

   // Scheduler FSM; reset drops any grant in progress without a timeout pulse.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_ptr       <= 4'd0;
         r_cnt       <= 8'd0;
         r_gnt       <= 16'd0;
         r_sel       <= 4'd0;
         r_gnt_valid <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_en && w_found) begin
                  r_state     <= S_GRANT;
                  r_gnt       <= 16'd1 << w_win;
                  r_sel       <= w_win;
                  r_gnt_valid <= 1'b1;
                  r_cnt       <= 8'd0;
               end else begin
                  // r_sel deliberately holds so the mux output stays stable
                  r_gnt       <= 16'd0;
                  r_gnt_valid <= 1'b0;
               end
            end
            S_GRANT: begin
               if (w_end) begin
                  r_state     <= S_IDLE;
                  r_gnt       <= 16'd0;
                  r_gnt_valid <= 1'b0;
                  r_ptr       <= r_sel + 4'd1;
                  // timeout only when the hold limit alone ended the grant
                  r_timeout   <= w_hold & ~i_release & w_keep;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_gnt       <= 16'd0;
               r_gnt_valid <= 1'b0;
            end
         endcase
      end
   end

   assign o_gnt       = r_gnt;
   assign o_sel       = r_sel;
   assign o_gnt_valid = r_gnt_valid;
   assign o_timeout   = r_timeout;

endmodule
